// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the multi-target SPI master
package spi_pkg;

  localparam int MAX_FRAME_W = 64;
  localparam int MAX_LW      = 7;
  localparam int MAX_TW      = 3;

  localparam int TGT_SYS = 0;
  localparam int TGT_DAC = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } spi_state_t;

  // Sized for the largest legal configuration; instances zero-extend into it.
  typedef struct packed {
    logic [MAX_FRAME_W-1:0] data;
    logic [MAX_LW-1:0]      len;
    logic [MAX_TW-1:0]      tgt;
  } spi_req_t;

  localparam int REQ_W = $bits(spi_req_t);

endpackage

// File: rtl/spi_req_slot.sv
// rtl/spi_req_slot.sv - one-entry pending request buffer for spi_master_mt
module spi_req_slot
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [REQ_W-1:0] push_req,
  input  logic             pop,
  output logic             full,
  output logic [REQ_W-1:0] req
);

  spi_req_t entry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (push && !full) begin
      full  <= 1'b1;
      entry <= spi_req_t'(push_req);
    end
  end

  assign req = entry;

endmodule

// File: rtl/spi_master_mt.sv
// rtl/spi_master_mt.sv - multi-target MSB-first SPI master with one pending request
// Readback capture on miso is built only when SPI_READBACK_EN is defined.
module spi_master_mt
  import spi_pkg::*;
#(
  parameter int FRAME_W = 40,
  parameter int NUM_TGT = 2,
  parameter int GAP_CYC = 2,
  localparam int TW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1,
  localparam int LW = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TW-1:0]      tgt_sel,
  input  logic [LW-1:0]      len,
  input  logic [FRAME_W-1:0] data_in,
  input  logic               miso,
  output logic               mosi,
  output logic [NUM_TGT-1:0] cs_b,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [FRAME_W-1:0] data_out,
  output logic               err
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW:0] NT = NUM_TGT[TW:0];

  spi_state_t state, state_n;

  logic [FRAME_W-1:0] sr;
  logic [LW-1:0]      cnt;
  logic [GW-1:0]      gcnt;
  logic [TW-1:0]      cur_tgt;

  logic             tgt_ok, last_bit;
  logic             load, use_slot, push, bad;
  logic             slot_full;
  logic [REQ_W-1:0] slot_vec;
  logic [LW-1:0]    len_eff, ld_len;
  spi_req_t         req_in, slot_q, ld_req;
  logic             unused_req;

  assign tgt_ok   = {1'b0, tgt_sel} < NT;
  assign last_bit = (state == SHIFT) && (cnt == '0);
  assign len_eff  = (len == '0 || len > LW'(FRAME_W)) ? LW'(FRAME_W) : len;

  always_comb begin
    req_in      = '0;
    req_in.data = MAX_FRAME_W'(data_in);
    req_in.len  = MAX_LW'(len_eff);
    req_in.tgt  = MAX_TW'(tgt_sel);
  end

  spi_req_slot u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (req_in),
    .pop      (use_slot),
    .full     (slot_full),
    .req      (slot_vec)
  );

  assign slot_q     = spi_req_t'(slot_vec);
  assign ld_req     = use_slot ? slot_q : req_in;
  assign ld_len     = ld_req.len[LW-1:0];
  assign unused_req = ^ld_req;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A start arriving on the last gap cycle with an empty slot is launched
  // directly rather than parked, so it cannot be stranded in IDLE.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    use_slot = 1'b0;
    push     = 1'b0;
    bad      = start && !tgt_ok;
    case (state)
      IDLE: begin
        if (start && tgt_ok) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (start && tgt_ok) begin
          if (slot_full) bad  = 1'b1;
          else           push = 1'b1;
        end
        if (cnt == '0) state_n = GAP;
      end
      GAP: begin
        if (start && tgt_ok) begin
          if (slot_full)       bad  = 1'b1;
          else if (gcnt != '0) push = 1'b1;
        end
        if (gcnt == '0) begin
          if (slot_full) begin
            load     = 1'b1;
            use_slot = 1'b1;
            state_n  = SHIFT;
          end else if (start && tgt_ok) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      cur_tgt <= TW'(TGT_SYS);
      done    <= 1'b0;
      wr_en   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done  <= last_bit;
      wr_en <= done;
      err   <= bad;
      if (load) begin
        sr      <= ld_req.data[FRAME_W-1:0] << (LW'(FRAME_W) - ld_len);
        cnt     <= ld_len - 1'b1;
        cur_tgt <= ld_req.tgt[TW-1:0];
      end else if (state == SHIFT) begin
        sr <= {sr[FRAME_W-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (last_bit)                       gcnt <= GW'(GAP_CYC - 1);
      else if (state == GAP && gcnt != '0) gcnt <= gcnt - 1'b1;
    end
  end

  assign mosi = (state == SHIFT) && sr[FRAME_W-1];
  assign busy = (state != IDLE);
  assign cs_b = (state == SHIFT) ? ~(NUM_TGT'(1) << cur_tgt) : '1;

`ifdef SPI_READBACK_EN
  logic [FRAME_W-1:0] rx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx       <= '0;
      data_out <= '0;
    end else begin
      if (load)                rx <= '0;
      else if (state == SHIFT) rx <= {rx[FRAME_W-2:0], miso};
      if (last_bit) data_out <= {rx[FRAME_W-2:0], miso};
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign data_out    = '0;
`endif

endmodule

// File: tb/tb_spi_master_mt.sv
// tb/tb_spi_master_mt.sv - directed and randomized self-checking bench for spi_master_mt
module tb_spi_master_mt;
  import spi_pkg::*;

  // Three targets so that an out-of-range index (3) is expressible on tgt_sel.
  localparam int FW  = 40;
  localparam int NT  = 3;
  localparam int GAP = 2;
  localparam int TW  = 2;
  localparam int LW  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] tgt_sel = '0;
  logic [LW-1:0] len = '0;
  logic [FW-1:0] data_in = '0;
  logic          miso_drv = 1'b0;
  logic          miso, mosi, busy, done, wr_en, err;
  logic [NT-1:0] cs_b;
  logic [FW-1:0] data_out;

  int checks = 0;
  int failures = 0;
  int miso_mode = 0;  // 0: loopback, 1: constant high, 2: random

  assign miso = (miso_mode == 0) ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_mt #(.FRAME_W(FW), .NUM_TGT(NT), .GAP_CYC(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tgt_sel  (tgt_sel),
    .len      (len),
    .data_in  (data_in),
    .miso     (miso),
    .mosi     (mosi),
    .cs_b     (cs_b),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .data_out (data_out),
    .err      (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NT-1:0] cs_exp(input int t);
    logic [NT-1:0] v;
    for (int i = 0; i < NT; i++) v[i] = (i != t);
    return v;
  endfunction

  task automatic launch(input logic [FW-1:0] d, input int lf, input int t);
    start   = 1'b1;
    data_in = d;
    len     = LW'(lf);
    tgt_sel = TW'(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after the edge that opened the frame; returns just after its last bit.
  task automatic shift_check(input logic [FW-1:0] d, input int L, input int t,
                             input int inj_k, input logic [FW-1:0] id, input int il, input int it,
                             input int bad_k, input int bad_t);
    logic [FW-1:0] rx;
    logic b;
    rx = '0;
    for (int k = 0; k < L; k++) begin
      check("cs_b", 64'(cs_b), 64'(cs_exp(t)));
      check("mosi", 64'(mosi), 64'(d[L-1-k]));
      check("busy", 64'(busy), 64'd1);
      check("done_mid", 64'(done), 64'd0);
      check("err", 64'(err), 64'((bad_k >= 0) && (k == bad_k + 1)));
      start   = 1'b0;
      data_in = FW'({$urandom, $urandom});
      if (k == inj_k) begin
        start = 1'b1; data_in = id; len = LW'(il); tgt_sel = TW'(it);
      end
      if (k == bad_k) begin
        start = 1'b1; len = LW'(8); tgt_sel = TW'(bad_t);
      end
      case (miso_mode)
        0:       b = d[L-1-k];
        1:       b = 1'b1;
        default: b = 1'($urandom);
      endcase
      miso_drv = b;
      rx = (rx << 1) | FW'(b);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_end", 64'(done), 64'd1);
    check("cs_b_end", 64'(cs_b), 64'(cs_exp(-1)));
    check("mosi_end", 64'(mosi), 64'd0);
`ifdef SPI_READBACK_EN
    check("data_out", 64'(data_out), 64'(rx));
`else
    check("data_out", 64'(data_out), 64'd0);
`endif
  endtask

  task automatic gap_check(input bit pending);
    for (int g = 1; g < GAP; g++) begin
      @(negedge clk);
      check("gap_cs_b", 64'(cs_b), 64'(cs_exp(-1)));
      check("gap_busy", 64'(busy), 64'd1);
      check("gap_wr_en", 64'(wr_en), 64'(g == 1));
      check("gap_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    check("gap_end_wr_en", 64'(wr_en), 64'(GAP == 1));
    if (!pending) begin
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_cs_b", 64'(cs_b), 64'(cs_exp(-1)));
    end
  endtask

  initial begin
    logic [FW-1:0] da, db;
    int la, lb, lf, t;

    repeat (2) @(negedge clk);
    check("rst_cs_b", 64'(cs_b), 64'(cs_exp(-1)));
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-length frame, miso looped back.
    miso_mode = 0;
    da = 40'hA5_0F0F_F0F0;
    launch(da, 40, TGT_SYS);
    shift_check(da, 40, TGT_SYS, -1, '0, 0, 0, -1, 0);
    gap_check(1'b0);

    // Short frame to the DAC, miso held high; upper payload bits must be ignored.
    miso_mode = 1;
    da = {32'($urandom), 8'h3C};
    launch(da, 8, TGT_DAC);
    shift_check(da, 8, TGT_DAC, -1, '0, 0, 0, -1, 0);
    gap_check(1'b0);

    // Back-to-back: second request parked during SHIFT.
    miso_mode = 2;
    da = FW'({$urandom, $urandom});
    db = FW'({$urandom, $urandom});
    launch(da, 12, 0);
    shift_check(da, 12, 0, 3, db, 9, 2, -1, 0);
    gap_check(1'b1);
    shift_check(db, 9, 2, -1, '0, 0, 0, -1, 0);
    gap_check(1'b0);

    // Slot-full rejection, then an out-of-range target while busy.
    da = FW'({$urandom, $urandom});
    db = FW'({$urandom, $urandom});
    launch(da, 16, 1);
    shift_check(da, 16, 1, 2, db, 5, 0, 5, 2);
    gap_check(1'b1);
    shift_check(db, 5, 0, -1, '0, 0, 0, 1, 3);
    gap_check(1'b0);

    // Out-of-range target from IDLE is rejected without starting a frame.
    start = 1'b1; tgt_sel = 2'd3; len = LW'(8); data_in = FW'({$urandom, $urandom});
    @(negedge clk);
    start = 1'b0;
    check("bad_tgt_err", 64'(err), 64'd1);
    check("bad_tgt_busy", 64'(busy), 64'd0);
    check("bad_tgt_cs_b", 64'(cs_b), 64'(cs_exp(-1)));
    @(negedge clk);
    check("bad_tgt_err_clr", 64'(err), 64'd0);
    check("bad_tgt_idle", 64'(busy), 64'd0);

    // len=0 selects the full frame width.
    miso_mode = 2;
    da = FW'({$urandom, $urandom});
    launch(da, 0, 1);
    shift_check(da, 40, 1, -1, '0, 0, 0, -1, 0);
    gap_check(1'b0);

    // Reset at bit 10 aborts the frame.
    miso_mode = 0;
    da = FW'({$urandom, $urandom});
    launch(da, 40, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_b", 64'(cs_b), 64'(cs_exp(-1)));
    check("abort_mosi", 64'(mosi), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_data_out", 64'(data_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_done2", 64'(done), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Randomized single frames.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      miso_mode = int'($urandom_range(0, 2));
      da = FW'({$urandom, $urandom});
      lf = int'($urandom_range(0, 40));
      t  = int'($urandom_range(0, 2));
      la = (lf == 0) ? 40 : lf;
      launch(da, lf, t);
      shift_check(da, la, t, -1, '0, 0, 0, -1, 0);
      gap_check(1'b0);
    end

    // Randomized back-to-back pair.
    miso_mode = 2;
    da = FW'({$urandom, $urandom});
    db = FW'({$urandom, $urandom});
    la = int'($urandom_range(4, 40));
    lb = int'($urandom_range(1, 40));
    launch(da, la, 2);
    shift_check(da, la, 2, 1, db, lb, 0, -1, 0);
    gap_check(1'b1);
    shift_check(db, lb, 0, -1, '0, 0, 0, -1, 0);
    gap_check(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
